// File: rtl/main_ctrl.sv
// Multicycle main controller: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter enabled by MAIN_CTRL_RETIRE_CNT_EN.
`timescale 1ns/1ps
module main_ctrl #(
  parameter logic [3:0] CMP_CMD = 4'b1010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rd,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        ir_write,
  output logic        next_pc,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_control,
  output logic        pcs,
  output logic        reg_w,
  output logic        mem_w,
  output logic [1:0]  flag_w,
  output logic        no_write,
  output logic        branch,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8, S_BRANCH = 4'd9
  } state_t;

  state_t r_state, w_next;

  logic [3:0] w_cmd;
  logic [1:0] w_alu_exec;
  logic       w_cmd_ok, w_arith;

  logic       w_mem_req, w_ir_write, w_next_pc, w_adr_src;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src, w_alu_control, w_flag_w;
  logic       w_reg_w, w_mem_w, w_no_write, w_branch, w_illegal;

  assign w_cmd = funct[4:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // cmd decode shared by both EXEC states and ALUWB
  always_comb begin
    w_alu_exec = 2'b00;
    w_cmd_ok   = 1'b1;
    w_arith    = 1'b0;
    if (w_cmd == CMP_CMD) begin
      w_alu_exec = 2'b01;
      w_arith    = 1'b1;
    end else begin
      case (w_cmd)
        4'b0100: begin w_alu_exec = 2'b00; w_arith = 1'b1; end
        4'b0010: begin w_alu_exec = 2'b01; w_arith = 1'b1; end
        4'b0000: w_alu_exec = 2'b10;
        4'b1100: w_alu_exec = 2'b11;
        default: w_cmd_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR,
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req     = 1'b0;
    w_ir_write    = 1'b0;
    w_next_pc     = 1'b0;
    w_adr_src     = 1'b0;
    w_alu_src_a   = 2'd0;
    w_alu_src_b   = 2'd0;
    w_result_src  = 2'd0;
    w_alu_control = 2'b00;
    w_reg_w       = 1'b0;
    w_mem_w       = 1'b0;
    w_flag_w      = 2'b00;
    w_no_write    = 1'b0;
    w_branch      = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_a  = 2'd1;
        w_alu_src_b  = 2'd2;
        w_result_src = 2'd2;
        w_ir_write   = mem_ready;
        w_next_pc    = mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a  = 2'd1;
        w_alu_src_b  = 2'd2;
        w_result_src = 2'd2;
        w_illegal    = (op == 2'b11);
      end
      S_MEMADR: w_alu_src_b = 2'd1;
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        w_mem_w   = mem_ready;
      end
      S_MEMWB: begin
        w_result_src = 2'd1;
        w_reg_w      = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        w_alu_src_b   = (r_state == S_EXECI) ? 2'd1 : 2'd0;
        w_alu_control = w_alu_exec;
        w_illegal     = ~w_cmd_ok;
        w_flag_w      = {funct[0], funct[0] & w_arith};
      end
      S_ALUWB: begin
        w_reg_w    = 1'b1;
        w_no_write = (w_cmd == CMP_CMD) | ~w_cmd_ok;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'd1;
        w_result_src = 2'd2;
        w_branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low while reset is held; everything else shows FETCH.
  assign mem_req     = w_mem_req  & reset_n;
  assign ir_write    = w_ir_write & reset_n;
  assign next_pc     = w_next_pc  & reset_n;
  assign reg_w       = w_reg_w    & reset_n;
  assign mem_w       = w_mem_w    & reset_n;
  assign branch      = w_branch   & reset_n;
  assign illegal_op  = w_illegal  & reset_n;
  assign flag_w      = w_flag_w & {2{reset_n}};
  assign pcs         = (w_branch | (w_reg_w & (rd == 4'hF))) & reset_n;
  assign adr_src     = w_adr_src;
  assign alu_src_a   = w_alu_src_a;
  assign alu_src_b   = w_alu_src_b;
  assign result_src  = w_result_src;
  assign alu_control = w_alu_control;
  assign no_write    = w_no_write;
  assign state       = r_state;

`ifdef MAIN_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retired;
  logic        w_retire;

  assign w_retire = (r_state == S_ALUWB) || (r_state == S_MEMWB) ||
                    (r_state == S_BRANCH) || ((r_state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_retired <= 32'd0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign instr_retired = r_retired;
`else
  assign instr_retired = 32'd0;
`endif

endmodule

// File: tb/tb_main_ctrl.sv
// Randomized bench for main_ctrl: per-instruction cycle traces from a trace model,
// compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_main_ctrl;

  typedef struct packed {
    logic        mem_req, ir_write, next_pc, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src, alu_control;
    logic        pcs, reg_w, mem_w;
    logic [1:0]  flag_w;
    logic        no_write, branch, illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_retired;
  } out_t;

  localparam logic [31:0] RET1 =
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    32'd1;
`else
    32'd0;
`endif

  logic        clk = 1'b0, reset_n;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        mem_ready;
  logic        mem_req, ir_write, next_pc, adr_src, pcs, reg_w, mem_w;
  logic        no_write, branch, illegal_op;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_control, flag_w;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  main_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
    .mem_ready(mem_ready), .mem_req(mem_req), .ir_write(ir_write),
    .next_pc(next_pc), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .flag_w(flag_w),
    .no_write(no_write), .branch(branch), .illegal_op(illegal_op),
    .state(state), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  out_t        dut_o, exp_o;
  bit          exp_valid = 1'b0;
  int          n_chk = 0, n_err = 0;
  out_t        obs[$];
  logic [1:0]  cur_op;
  logic [5:0]  cur_funct;
  logic [3:0]  cur_rd;
  logic [31:0] mcnt = 32'd0;

  assign dut_o = {mem_req, ir_write, next_pc, adr_src, alu_src_a, alu_src_b,
                  result_src, alu_control, pcs, reg_w, mem_w, flag_w,
                  no_write, branch, illegal_op, state, instr_retired};

  // Expected outputs for one cycle spent in spec state st with the given inputs.
  function automatic out_t model(int st, logic [1:0] o, logic [5:0] f,
                                 logic [3:0] r, logic mr, logic [31:0] cnt, bit rst);
    out_t e;
    logic [3:0] c;
    logic [3:0] sc;
    bit s, legal;
    e = '0;
    c = f[4:1];
    s = f[0];
    sc = st[3:0];
    legal = c inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    e.state = sc;
    e.instr_retired = cnt;
    if (rst) begin
      e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
      e.state = 4'd0; e.instr_retired = 32'd0;
      return e;
    end
    case (st)
      0: begin
        e.mem_req = 1; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
        e.ir_write = mr; e.next_pc = mr;
      end
      1: begin
        e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
        e.illegal_op = (o == 2'b11);
      end
      2: e.alu_src_b = 2'd1;
      3: begin e.mem_req = 1; e.adr_src = 1; end
      4: begin e.result_src = 2'd1; e.reg_w = 1; end
      5: begin e.mem_req = 1; e.adr_src = 1; e.mem_w = mr; end
      6, 7: begin
        e.alu_src_b = (st == 7) ? 2'd1 : 2'd0;
        case (c)
          4'b0100: e.alu_control = 2'b00;
          4'b0010: e.alu_control = 2'b01;
          4'b0000: e.alu_control = 2'b10;
          4'b1100: e.alu_control = 2'b11;
          4'b1010: e.alu_control = 2'b01;
          default: e.illegal_op = 1;
        endcase
        e.flag_w = {s, s && (c inside {4'b0100, 4'b0010, 4'b1010})};
      end
      8: begin e.reg_w = 1; e.no_write = (c == 4'b1010) || !legal; end
      9: begin e.alu_src_b = 2'd1; e.result_src = 2'd2; e.branch = 1; end
      default: ;
    endcase
    e.pcs = e.branch | (e.reg_w & (r == 4'd15));
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      n_chk++;
      if (dut_o !== exp_o) begin
        n_err++;
        $display("FAIL cycle_compare t=%0t got=%h want=%h", $time, dut_o, exp_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock cycle spent in spec state st.
  task automatic cyc(input int st, input logic mr);
    @(posedge clk);
    #1;
    op = cur_op; funct = cur_funct; rd = cur_rd; mem_ready = mr;
    exp_o = model(st, cur_op, cur_funct, cur_rd, mr, mcnt, 1'b0);
    #2;
    obs.push_back(dut_o);
  endtask

  // Whole instruction: fw fetch stall cycles, mw memory stall cycles.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input int fw, input int mw);
    obs.delete();
    cur_op = o; cur_funct = f; cur_rd = r;
    for (int i = 0; i <= fw; i++) cyc(0, i == fw);
    cyc(1, 1'($urandom));
    case (o)
      2'b00: begin cyc(f[5] ? 7 : 6, 1'($urandom)); cyc(8, 1'($urandom)); end
      2'b01: begin
        cyc(2, 1'($urandom));
        if (f[0]) begin
          for (int j = 0; j <= mw; j++) cyc(3, j == mw);
          cyc(4, 1'($urandom));
        end else begin
          for (int j = 0; j <= mw; j++) cyc(5, j == mw);
        end
      end
      2'b10: cyc(9, 1'($urandom));
      default: ;
    endcase
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    if (o != 2'b11) mcnt = mcnt + 32'd1;
`endif
  endtask

  function automatic logic [5:0] rand_funct();
    logic [3:0] legal [5];
    logic [3:0] c;
    legal = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    c = ($urandom % 5 == 0) ? 4'($urandom) : legal[$urandom % 5];
    return {1'($urandom), c, 1'($urandom)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    reset_n = 1'b0; mem_ready = 1'b0; op = '0; funct = '0; rd = '0;
    cur_op = '0; cur_funct = '0; cur_rd = '0;
    exp_o = model(0, 2'b00, 6'd0, 4'd0, 1'b0, 32'd0, 1'b1);
    exp_valid = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    reset_n = 1'b1;
    exp_o = model(0, cur_op, cur_funct, cur_rd, 1'b0, mcnt, 1'b0);

    // reset asserted while MEMRD is waiting
    cur_op = 2'b01; cur_funct = 6'b000001; cur_rd = 4'd2;
    cyc(0, 1'b1); cyc(1, 1'b0); cyc(2, 1'b1); cyc(3, 1'b0);
    chk("pre_rst_state", 32'(state), 32'd3);
    #1;
    reset_n = 1'b0;
    mcnt = 32'd0;
    exp_o = model(0, cur_op, cur_funct, cur_rd, 1'b0, mcnt, 1'b1);
    #0.5;
    chk("rst_state_async", 32'(state), 32'd0);
    @(posedge clk);
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    #1;
    reset_n = 1'b1;
    exp_o = model(0, cur_op, cur_funct, cur_rd, 1'b0, mcnt, 1'b0);

    // branch with a 3-cycle fetch stall
    run_instr(2'b10, 6'b000000, 4'd5, 3, 0);
    chk("rel_mem_req", 32'(obs[0].mem_req), 32'd1);
    chk("rel_retired", obs[0].instr_retired, 32'd0);
    sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(obs[i].ir_write);
    chk("fetch_irw_count", 32'(sum), 32'd1);
    chk("fetch_irw_c4", 32'(obs[3].ir_write), 32'd1);
    chk("fetch_npc_c4", 32'(obs[3].next_pc), 32'd1);
    chk("fetch_then_decode", 32'(obs[4].state), 32'd1);
    chk("br_branch", 32'(obs[5].branch), 32'd1);
    chk("br_pcs", 32'(obs[5].pcs), 32'd1);

    // illegal op
    run_instr(2'b11, 6'b000000, 4'd0, 0, 0);
    chk("ret_after_branch", obs[0].instr_retired, RET1);
    chk("ill_len", 32'(obs.size()), 32'd2);
    chk("ill_pulse", 32'(obs[1].illegal_op), 32'd1);

    // ADDS immediate, rd=3
    run_instr(2'b00, 6'b101001, 4'd3, 0, 0);
    chk("ret_after_ill", obs[0].instr_retired, RET1);
    chk("adds_states", {obs[0].state, obs[1].state, obs[2].state, obs[3].state}, 32'h0178);
    chk("adds_alu", 32'(obs[2].alu_control), 32'd0);
    chk("adds_flag", 32'(obs[2].flag_w), 32'd3);
    chk("adds_regw", 32'(obs[3].reg_w), 32'd1);
    chk("adds_pcs", 32'(obs[3].pcs), 32'd0);

    // CMP register with S
    run_instr(2'b00, 6'b010101, 4'd4, 0, 0);
    chk("cmp_state", 32'(obs[2].state), 32'd6);
    chk("cmp_alu", 32'(obs[2].alu_control), 32'd1);
    chk("cmp_flag", 32'(obs[2].flag_w), 32'd3);
    chk("cmp_nowrite", 32'(obs[3].no_write), 32'd1);

    // load with 2-cycle memory stall
    run_instr(2'b01, 6'b000001, 4'd7, 0, 2);
    chk("ldr_states", {obs[0].state, obs[1].state, obs[2].state, obs[3].state,
                       obs[4].state, obs[5].state, obs[6].state}, 32'h0123334);
    chk("ldr_rsrc", 32'(obs[6].result_src), 32'd1);
    chk("ldr_regw", 32'(obs[6].reg_w), 32'd1);

    // store to rd=15 with 2-cycle memory stall
    run_instr(2'b01, 6'b000000, 4'd15, 0, 2);
    chk("str_states", {obs[0].state, obs[1].state, obs[2].state, obs[3].state,
                       obs[4].state, obs[5].state}, 32'h012555);
    chk("str_memw", {obs[3].mem_w, obs[4].mem_w, obs[5].mem_w}, 32'b001);
    chk("str_pcs", 32'(obs[5].pcs), 32'd0);

    for (int n = 0; n < 300; n++)
      run_instr(2'($urandom), rand_funct(), 4'($urandom), $urandom % 4, $urandom % 4);

    cur_op = 2'b00;
    cyc(0, 1'b0);
    chk("final_fetch", 32'(obs[$].state), 32'd0);
    chk("final_retired", obs[$].instr_retired, mcnt);
    #3;
    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/main_ctrl.md
Name: main_ctrl

Overview:
Multicycle main controller FSM that sequences the shared datapath through fetch, decode, execute, memory and writeback, one instruction at a time. Its raw enables (pcs, reg_w, mem_w, flag_w, no_write) feed cond_logic, which gates them with the condition check. Memory accesses stall on a mem_ready handshake.

Parameters:
CMP_CMD, 4'b1010, cmd encoding for compare. Compare updates flags and suppresses register write.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal
funct  in  6  [5]=I (immediate), [4:1]=cmd, [0]=S (for data-processing) / L (load, for memory)
rd  in  4  destination register index
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access in progress
ir_write  out  1  latch instruction register
next_pc  out  1  write PC with result
adr_src  out  1  0=PC, 1=result as memory address
alu_src_a  out  2  0=reg A, 1=PC
alu_src_b  out  2  0=reg B, 1=immediate, 2=constant 4
result_src  out  2  0=ALU out reg, 1=read data, 2=ALU direct
alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
pcs  out  1  raw PC-source request to cond_logic
reg_w  out  1  raw register write
mem_w  out  1  raw memory write
flag_w  out  2  raw flag write, [1]=NZ, [0]=CV
no_write  out  1  suppress register write (compare)
branch  out  1  branch state active
illegal_op  out  1  one-cycle pulse on unsupported op or cmd
state  out  4  current state, debug
instr_retired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are unreachable and return to FETCH on the next clock.
- Reset: async. While reset_n=0:
  - state=FETCH.
  - mem_req, ir_write, next_pc, reg_w, mem_w, pcs, flag_w, branch and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
- A reset asserted mid-instruction abandons that instruction; nothing is retired.
- Outputs are decoded combinationally from the registered state plus op/funct/rd. There is no output latency beyond the state register.
- Transitions:
  - FETCH: holds until mem_ready=1, then goes to DECODE.
  - DECODE: op=00 goes to EXECI if funct[5]=1, else EXECR. op=01 goes to MEMADR. op=10 goes to BRANCH. op=11 goes to FETCH and pulses illegal_op.
  - MEMADR goes to MEMRD if L=1, else MEMWR.
  - MEMRD holds until mem_ready, then goes to MEMWB. MEMWR holds until mem_ready, then goes to FETCH.
  - EXECR and EXECI go to ALUWB. ALUWB, MEMWB and BRANCH go to FETCH.
- FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=2, alu_control=00, result_src=2. ir_write and next_pc are asserted only in the cycle where mem_ready=1.
- DECODE: alu_src_a=1, alu_src_b=2, alu_control=00, result_src=2 (PC+8).
- MEMADR: alu_src_a=0, alu_src_b=1, alu_control=00.
- MEMRD: mem_req=1, adr_src=1, result_src=0.
- MEMWR: mem_req=1, adr_src=1, result_src=0. mem_w is asserted only while mem_ready=1.
- MEMWB: result_src=1, reg_w=1.
- EXECR: alu_src_a=0, alu_src_b=0. EXECI: alu_src_a=0, alu_src_b=1.
- In both EXEC states, cmd maps to alu_control as follows: 0100 gives 00, 0010 gives 01, 0000 gives 10, 1100 gives 11, CMP_CMD gives 01.
- In both EXEC states, any other cmd gives alu_control 00, pulses illegal_op and still completes through ALUWB with no_write=1.
- In both EXEC states: flag_w[1]=S; flag_w[0]=S & (cmd is ADD, SUB or CMP).
- ALUWB: result_src=0, reg_w=1. no_write=1 when cmd=CMP_CMD or cmd is illegal.
- BRANCH: alu_src_a=0, alu_src_b=1, alu_control=00, result_src=2, branch=1.
- pcs = branch | (reg_w & rd==15).
- Unlisted outputs are 0 in each state.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Optional Feature:
Macro MAIN_CTRL_RETIRE_CNT_EN.
- Defined: instr_retired resets to 0 and increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH. It wraps from 0xFFFFFFFF to 0. The illegal-op return (DECODE to FETCH) does not count.
- Undefined: instr_retired is constant 0 and no counter is built.

Test Plan:
- Reset low mid-MEMRD, then release: state=0 immediately; mem_req=0 during reset; mem_req=1 after release; instr_retired unchanged.
- FETCH with mem_ready low for 3 cycles then high: ir_write/next_pc pulse exactly once, in cycle 4; then state=1.
- op=00, funct=6'b101001 (ADDS imm), rd=3: states 0→1→7→8→0. In EXECI, alu_control=00 and flag_w=11. In ALUWB, reg_w=1, pcs=0.
- op=00, funct=6'b010101 (CMP reg, S): EXECR with alu_control=01, flag_w=11; ALUWB with no_write=1.
- op=01, L=1 with mem_ready delayed 2 cycles in MEMRD: MEMRD held 3 cycles, then MEMWB with result_src=1, reg_w=1. With L=0 and rd=15: mem_w asserted only in the ready cycle.
- op=10: BRANCH with branch=1, pcs=1. op=11: illegal_op pulses for one cycle and the FSM returns to FETCH. With the macro defined, instr_retired increments after BRANCH but not after the illegal op.
